// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer that owns HI/LO.
//   Iterative MULT/MULTU/DIV/DIVU, one bit per cycle (IDLE -> CALC -> FIX).
//   MFHI/MFLO read HI/LO combinationally; MTHI/MTLO write at the accepting edge.
// Ports:
//   clk, nrst            rising-edge clock, synchronous active-low reset
//   i_EX_ctrl_MDStart    HI/LO-class instruction present in EX
//   i_EX_ctrl_MDOp       0 MULT 1 MULTU 2 DIV 3 DIVU 4 MFHI 5 MFLO 6 MTHI 7 MTLO
//   i_EX_data_A/B        rs / rt operands
//   o_EX_data_MDOut      HI for MFHI, LO for MFLO, else 0
//   o_EX_ctrl_Stall      HI/LO-class instruction in EX while busy
//   o_EX_ctrl_Busy       operation in flight
//   o_EX_ctrl_Done       one-cycle pulse after HI/LO written by mul/div
//   o_EX_ctrl_DivZero    pulses with Done when the divisor was zero
module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_EX_ctrl_MDStart,
  input  logic [2:0]       i_EX_ctrl_MDOp,
  input  logic [WIDTH-1:0] i_EX_data_A,
  input  logic [WIDTH-1:0] i_EX_data_B,
  output logic [WIDTH-1:0] o_EX_data_MDOut,
  output logic             o_EX_ctrl_Stall,
  output logic             o_EX_ctrl_Busy,
  output logic             o_EX_ctrl_Done,
  output logic             o_EX_ctrl_DivZero
);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic                 is_div_q, is_div_d, dz_q, dz_d;
  logic                 done_q, done_d, divz_q, divz_d;

  logic                 sgn_op;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     ext;
  logic [WIDTH:0]       rem_sh, rem_sub;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    divz_d   = 1'b0;
    sgn_op   = 1'b0;
    sum      = '0;
    ext      = '0;
    rem_sh   = '0;
    rem_sub  = '0;
    prod     = '0;
    quo      = '0;
    rem      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_EX_ctrl_MDStart) begin
          unique case (i_EX_ctrl_MDOp)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              sgn_op   = ~i_EX_ctrl_MDOp[0];
              sa_d     = sgn_op & i_EX_data_A[WIDTH-1];
              sb_d     = sgn_op & i_EX_data_B[WIDTH-1];
              a_d      = sa_d ? -i_EX_data_A : i_EX_data_A;
              b_d      = sb_d ? -i_EX_data_B : i_EX_data_B;
              is_div_d = i_EX_ctrl_MDOp[1];
              dz_d     = i_EX_ctrl_MDOp[1] && (i_EX_data_B == '0);
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = ST_CALC;
            end
            3'd6:    hi_d = i_EX_data_A;
            3'd7:    lo_d = i_EX_data_A;
            default: ;
          endcase
        end
      end

      ST_CALC: begin
        if (!is_div_q) begin
          // Shift-add: add multiplicand into upper half, then shift the
          // whole product (with carry) right; multiplier consumed LSB-first.
          sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
          ext   = {sum, acc_q[WIDTH-1:0]};
          acc_d = ext[2*WIDTH:1];
          b_d   = b_q >> 1;
        end else begin
          // Restoring divide: acc = {remainder, quotient}; dividend bits
          // are shifted out of a_q MSB-first.
          rem_sh = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
          if (rem_sh >= {1'b0, b_q}) begin
            rem_sub = rem_sh - {1'b0, b_q};
            acc_d   = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d   = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
          a_d = a_q << 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_FIX;
      end

      ST_FIX: begin
        if (!is_div_q) begin
          prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          quo  = acc_q[WIDTH-1:0];
          rem  = acc_q[2*WIDTH-1:WIDTH];
          lo_d = (sa_q ^ sb_q) ? -quo : quo;
          hi_d = sa_q ? -rem : rem;
        end
        done_d  = 1'b1;
        divz_d  = is_div_q & dz_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
    end
  end

  always_comb begin
    o_EX_data_MDOut = '0;
    if (i_EX_ctrl_MDStart) begin
      if (i_EX_ctrl_MDOp == 3'd4)      o_EX_data_MDOut = hi_q;
      else if (i_EX_ctrl_MDOp == 3'd5) o_EX_data_MDOut = lo_q;
    end
  end

  assign o_EX_ctrl_Busy    = (state_q != ST_IDLE);
  assign o_EX_ctrl_Stall   = i_EX_ctrl_MDStart && o_EX_ctrl_Busy;
  assign o_EX_ctrl_Done    = done_q;
  assign o_EX_ctrl_DivZero = divz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [31:0] mdout;
  logic        stall, busy, done, divz;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk               (clk),
    .nrst              (nrst),
    .i_EX_ctrl_MDStart (start),
    .i_EX_ctrl_MDOp    (op),
    .i_EX_data_A       (a),
    .i_EX_data_B       (b),
    .o_EX_data_MDOut   (mdout),
    .o_EX_ctrl_Stall   (stall),
    .o_EX_ctrl_Busy    (busy),
    .o_EX_ctrl_Done    (done),
    .o_EX_ctrl_DivZero (divz)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for a completed mul/div.
  function automatic void mdl(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                              output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
    longint sx, sy, p, q, r;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    rdz = 1'b0;
    rhi = '0;
    rlo = '0;
    case (o)
      3'd0: begin p = sx * sy; rhi = p[63:32]; rlo = p[31:0]; end
      3'd1: begin up = ux * uy; rhi = up[63:32]; rlo = up[31:0]; end
      3'd2: begin
        if (y == 0) begin
          rdz = 1'b1;
          rlo = x[31] ? 32'h1 : 32'hFFFF_FFFF;
          rhi = x;
        end else begin
          q = sx / sy; r = sx % sy;
          rlo = q[31:0]; rhi = r[31:0];
        end
      end
      3'd3: begin
        if (y == 0) begin rdz = 1'b1; rlo = 32'hFFFF_FFFF; rhi = x; end
        else begin rlo = x / y; rhi = x % y; end
      end
      default: ;
    endcase
  endfunction

  // Model: an accepted mul/div lands in HI/LO 33 edges later.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done, m_dz, p_dz;
  int          m_rem;

  always @(posedge clk) begin
    if (!nrst) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_done = 0; m_dz = 0;
    end else begin
      m_done = 0; m_dz = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1; m_dz = p_dz;
        end
      end else if (start) begin
        case (op)
          3'd0, 3'd1, 3'd2, 3'd3: begin mdl(op, a, b, p_hi, p_lo, p_dz); m_rem = 33; end
          3'd6: m_hi = a;
          3'd7: m_lo = a;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_rem > 0});
      chk("stall", {31'b0, stall}, {31'b0, start && (m_rem > 0)});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("divzero", {31'b0, divz}, {31'b0, m_dz});
      if (start) chk("mdout", mdout, (op == 3'd4) ? m_hi : (op == 3'd5) ? m_lo : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic idle();
    start = 0; op = 0; a = 0; b = 0;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1; op = o; a = x; b = y;
    step();
    idle();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 60) begin step(); n++; end
    if (busy !== 1'b0) chk({name, "_timeout"}, {31'b0, busy}, 32'h0);
  endtask

  task automatic read(input string name, input logic [31:0] eh, input logic [31:0] el);
    start = 1; op = 3'd4; #1;
    chk({name, "_hi"}, mdout, eh);
    chk({name, "_mhi"}, m_hi, eh);
    op = 3'd5; #1;
    chk({name, "_lo"}, mdout, el);
    chk({name, "_mlo"}, m_lo, el);
    idle();
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el, input logic edz);
    issue(o, x, y);
    wait_idle(name);
    chk({name, "_done"}, {31'b0, done}, 32'h1);
    chk({name, "_dz"}, {31'b0, divz}, {31'b0, edz});
    read(name, eh, el);
    step();
  endtask

  initial begin
    int n;
    idle();
    nrst = 0;
    step(); step();
    nrst = 1;
    chk_en = 1;

    read("reset", 32'h0, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    step();

    run("mult",   3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run("multu",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run("div",    3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("divu0",  3'd3, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    run("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run("divneg0",3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'h0000_0001, 1'b1);
    run("divu",   3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);

    // MFLO held behind a running MULT: stalled for E1..E33.
    issue(3'd0, 32'd6, 32'd7);
    start = 1; op = 3'd5;
    n = 0;
    while (stall === 1'b1 && n < 100) begin n++; step(); end
    chk("stall_cycles", 32'(n), 32'd33);
    #1 chk("stall_mflo", mdout, 32'd42);
    idle();
    step();

    // MTHI in IDLE: no stall, HI visible next cycle.
    start = 1; op = 3'd6; a = 32'h1234_5678; #1;
    chk("mthi_stall", {31'b0, stall}, 32'h0);
    step(); idle();
    read("mthi", 32'h1234_5678, 32'd42);
    step();

    // MTLO presented while busy and then withdrawn has no effect.
    issue(3'd1, 32'd2, 32'd3);
    start = 1; op = 3'd7; a = 32'hDEAD_BEEF;
    step(); step(); step();
    idle();
    wait_idle("mtlo_busy");
    read("mtlo_busy", 32'h0, 32'd6);
    step();

    // Reset during DIV at counter=10 abandons it.
    issue(3'd2, 32'd100, 32'd3);
    repeat (10) step();
    nrst = 0;
    step();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    nrst = 1;
    read("rst", 32'h0, 32'h0);
    repeat (30) step();
    chk("rst_nodone", {31'b0, done}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer beside the EX-stage ALU. Owns the HI/LO architectural registers and sequences iterative MULT/MULTU/DIV/DIVU, one bit per cycle.
- Serves MFHI/MFLO/MTHI/MTLO.
- Raises a pipeline stall when a HI/LO-class instruction reaches EX while an operation is still running.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits; iteration count is WIDTH.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  synchronous active-low reset
- i_EX_ctrl_MDStart  in  1  HI/LO-class instruction present in EX this cycle
- i_EX_ctrl_MDOp  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO
- i_EX_data_A  in  WIDTH  rs operand
- i_EX_data_B  in  WIDTH  rt operand
- o_EX_data_MDOut  out  WIDTH  HI for MFHI, LO for MFLO, else 0 (combinational)
- o_EX_ctrl_Stall  out  1  freeze IF/ID/EX, bubble into MEM
- o_EX_ctrl_Busy  out  1  operation in flight
- o_EX_ctrl_Done  out  1  one-cycle pulse: HI/LO just updated by mul/div
- o_EX_ctrl_DivZero  out  1  one-cycle pulse with Done when divisor was 0

Behaviour:
- Reset: nrst sampled low at a rising edge forces the following.
  - state=IDLE; HI, LO, counter and all internal registers = 0.
  - Busy, Done, DivZero = 0.
  - Reset mid-operation abandons the operation; HI/LO are 0, not partial results.
- FSM: IDLE -> CALC -> FIX -> IDLE. Busy = (state != IDLE).
- Stall = MDStart && Busy (combinational). A stalled instruction is held in EX by the pipeline and re-presented each cycle; no other condition stalls.
- IDLE with MDStart:
  - Ops 0-3: accept at edge E0.
    - Latch sign flags.
    - Latch operand magnitudes: absolute value for MULT/DIV, raw for MULTU/DIVU.
    - Latch op kind and divisor-zero flag.
    - Clear the 2*WIDTH accumulator; counter=0; go to CALC.
  - Op 6 (MTHI): HI<=A at that edge, state stays IDLE.
  - Op 7 (MTLO): LO<=A at that edge, state stays IDLE.
  - Ops 4-5: no state change; MDOut supplies data the same cycle.
- CALC, one iteration per edge E1..E32 (WIDTH iterations):
  - Multiply: shift-add on the 2*WIDTH product, LSB-first multiplier.
  - Divide: restoring. Shift remainder left, bring in the next dividend bit MSB-first, subtract divisor if remainder >= divisor, set the quotient bit.
  - Counter increments each edge; at count WIDTH-1 go to FIX.
- FIX, edge E33: apply sign correction, then write HI/LO, go to IDLE.
  - MULT: negate the 2*WIDTH product if signs differ. HI=upper, LO=lower.
  - DIV: negate the quotient if signs differ; remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - MULTU/DIVU: no correction.
  - All negation is two's complement, modulo width; no saturation.
- Done and DivZero are registered, high for exactly the one cycle after E33.
- Latency: new HI/LO are readable by an MFHI/MFLO presented in the cycle after E33. Busy is high for cycles E0..E33 (33 cycles).
- Divide by zero (DIV or DIVU with B=0):
  - No trap, normal latency.
  - Raw result LO=all ones, HI=|A|. Sign correction per DIV still applies.
  - DivZero pulses.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no flag).
- HI/LO-class op while Busy (including MTHI/MTLO): stalled, no HI/LO effect until accepted in IDLE.
- MDStart in the same cycle state returns to IDLE: still stalled, because Busy is high in the FIX cycle. Accepted the next cycle.
- Out-of-range handling: none needed; every 3-bit op encoding is defined.

Test Plan:
- Reset, then MFHI and MFLO -> MDOut=0x00000000 both; Busy=0; Stall=0.
- MULT A=0xFFFFFFFD (-3), B=5 -> Done pulse one cycle after E33; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=0x00000007; DivZero and Done pulse together.
- MULT accepted, MFLO held with MDStart the next cycle -> Stall high for exactly 33 cycles (E1..E33). Then MDOut shows the new LO.
- MTHI A=0x12345678 in IDLE -> HI=0x12345678 next cycle; no stall.
- Reset asserted at counter=10 during DIV -> next cycle IDLE, Busy=0, HI=LO=0, no Done pulse.
